// File: rtl/bus_pkg.sv
// Shared definitions for the slave return-line arbiter: FSM state encoding,
// default geometry and the width of a slave index.
package bus_pkg;

  // Default number of slaves sharing the master serial return line.
  localparam int DEFAULT_N_SLAVES = 3;

  // Default number of serial bits carried by one granted frame.
  localparam int DEFAULT_FRAME_BITS = 8;

  // Width of a slave index; covers up to four slaves.
  localparam int SLAVE_ID_W = 2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/slave_tx_arbiter_rr_picker.sv
// Round-robin priority picker.
// Combinational: searches req starting at last+1 and wrapping to 0, returning
// the first set index as winner. any is high when at least one request is set.
// The slave that won last time is checked last, so every requester is served
// within N_SLAVES frames.
module rr_priority_picker
  import bus_pkg::*;
#(
  parameter int N_SLAVES = DEFAULT_N_SLAVES
) (
  input  logic [N_SLAVES-1:0]   req,
  input  logic [SLAVE_ID_W-1:0] last,
  output logic [SLAVE_ID_W-1:0] winner,
  output logic                  any
);

  logic [SLAVE_ID_W-1:0] idx;

  // Walk the N_SLAVES candidates in rotated order; the first hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_SLAVES; k++) begin
      idx = SLAVE_ID_W'((int'(last) + k) % N_SLAVES);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_tx_arbiter.sv
// Slave transmit arbiter.
// Several slaves share one serial return line to the master. When the master
// is ready, one requesting slave is chosen round-robin, granted, and its
// serial bits are registered onto master_rx_data for FRAME_BITS cycles. The
// arbiter then waits for the slave's done flag before the next frame.
//
// Handshake: a frame starts only in IDLE when master_ready=1 and at least one
// slave_req bit is set. Once started, slave_req and master_ready are ignored
// until the frame is finished; grant (which feeds each slave's master_ready)
// is high for the GRANT cycle and all XFER cycles, and master_valid marks each
// registered bit, one cycle after the bit was sampled from the slave.
//
// Optional build macro ARB_TIMEOUT_EN: adds a RELEASE watchdog. If the winner
// does not raise slave_tx_done within TIMEOUT_CYCLES RELEASE cycles, the FSM is
// forced back to IDLE, round-robin advances past the winner, and timeout_err
// pulses for one cycle. Without the macro RELEASE waits indefinitely and
// timeout_err is tied low.
module slave_tx_arbiter
  import bus_pkg::*;
#(
  parameter int N_SLAVES       = DEFAULT_N_SLAVES,
  parameter int FRAME_BITS     = DEFAULT_FRAME_BITS,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SLAVES-1:0]   slave_req,
  input  logic [N_SLAVES-1:0]   slave_tx_data,
  input  logic [N_SLAVES-1:0]   slave_tx_done,
  input  logic                  master_ready,
  output logic [N_SLAVES-1:0]   grant,
  output logic                  master_valid,
  output logic                  master_rx_data,
  output logic [SLAVE_ID_W-1:0] master_slave_id,
  output logic                  busy,
  output logic                  timeout_err,
  output arb_state_t            dbg_state
);

  // bit_cnt holds 0..FRAME_BITS-1 plus headroom so it never wraps in a frame.
  localparam int CNT_W = $clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  // After reset the highest index counts as last winner, so slave 0 goes first.
  localparam logic [SLAVE_ID_W-1:0] RESET_LAST = SLAVE_ID_W'(N_SLAVES - 1);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [SLAVE_ID_W-1:0] winner_q;
  logic [SLAVE_ID_W-1:0] winner_d;
  logic [SLAVE_ID_W-1:0] last_q;
  logic [SLAVE_ID_W-1:0] last_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_d;
  logic [SLAVE_ID_W-1:0] pick;
  logic                  pick_any;
  logic                  winner_done;
  logic                  winner_bit;
  logic                  force_release;

  // Round-robin choice among current requesters, relative to last winner.
  rr_priority_picker #(
    .N_SLAVES(N_SLAVES)
  ) u_picker (
    .req    (slave_req),
    .last   (last_q),
    .winner (pick),
    .any    (pick_any)
  );

  assign winner_done = slave_tx_done[winner_q];
  assign winner_bit  = slave_tx_data[winner_q];

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Watchdog: counts RELEASE cycles spent waiting for the winner's done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == RELEASE && !winner_done) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // Fires in the last allowed RELEASE cycle; the FSM leaves RELEASE on the
  // next edge, so the pulse is exactly one cycle wide.
  assign force_release = (state_q == RELEASE) && !winner_done && (wd_q == WD_LAST);
`else
  assign force_release = 1'b0;
`endif

  assign timeout_err = force_release;

  // State, winner, round-robin pointer and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      winner_q  <= '0;
      last_q    <= RESET_LAST;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then run the frame to completion.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (master_ready && pick_any) begin
          state_d  = GRANT;
          winner_d = pick;
        end
      end
      GRANT: begin
        state_d   = XFER;
        bit_cnt_d = '0;
      end
      XFER: begin
        // Counter stops at the last bit rather than wrapping.
        if (bit_cnt_q == LAST_BIT) begin
          state_d = RELEASE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // A forced release also advances the pointer past the stuck slave.
        if (winner_done || force_release) begin
          state_d = IDLE;
          last_d  = winner_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-hot grant to the winner during GRANT and XFER only.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      grant[i] = ((state_q == GRANT) || (state_q == XFER)) &&
                 (winner_q == SLAVE_ID_W'(i));
    end
  end

  // Serial bit register: each XFER cycle captures the winner's bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      master_valid   <= 1'b0;
      master_rx_data <= 1'b0;
    end else begin
      master_valid   <= (state_q == XFER);
      master_rx_data <= (state_q == XFER) ? winner_bit : 1'b0;
    end
  end

  assign busy            = (state_q != IDLE);
  assign master_slave_id = busy ? winner_q : '0;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// Directed testbench for slave_tx_arbiter (default N_SLAVES=3, FRAME_BITS=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_slave_tx_arbiter;
  import bus_pkg::*;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          slave_req;
  logic [N-1:0]          slave_tx_data;
  logic [N-1:0]          slave_tx_done;
  logic                  master_ready;
  logic [N-1:0]          grant;
  logic                  master_valid;
  logic                  master_rx_data;
  logic [SLAVE_ID_W-1:0] master_slave_id;
  logic                  busy;
  logic                  timeout_err;
  arb_state_t            dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard of serial bits expected on master_rx_data.
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  slave_tx_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .slave_req       (slave_req),
    .slave_tx_data   (slave_tx_data),
    .slave_tx_done   (slave_tx_done),
    .master_ready    (master_ready),
    .grant           (grant),
    .master_valid    (master_valid),
    .master_rx_data  (master_rx_data),
    .master_slave_id (master_slave_id),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; grant must never be multi-hot.
  task automatic tick();
    @(negedge clk);
    check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == '0 && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 80) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [N-1:0] rr_exp [4];
  logic [7:0]   byte_v;
  int           cyc;
  int           nvalid;
  int           bi;
  int           rel;
  int           pulses;
  int           pulse_at;
  int           stuck;

  initial begin
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;

    reset         = 1'b1;
    slave_req     = '0;
    slave_tx_data = '0;
    slave_tx_done = 3'b111;
    master_ready  = 1'b0;

    // Reset state.
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(master_valid), 32'd0);
    check("rst_rxdata", 32'(master_rx_data), 32'd0);
    check("rst_id", 32'(master_slave_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;

    // Round-robin over four frames with everyone requesting.
    slave_req    = 3'b111;
    master_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_grant("rr_wait_grant");
      check("rr_grant", 32'(grant), 32'(rr_exp[f]));
      check("rr_id", 32'(master_slave_id), 32'($clog2(rr_exp[f])));
      wait_idle(cyc);
      // GRANT + 8 XFER + 1 RELEASE, then one IDLE cycle.
      check("rr_frame_len", 32'(cyc), 32'd10);
      check("rr_idle_id", 32'(master_slave_id), 32'd0);
      if (f == 3) slave_req = 3'b010;
    end

    // Slave 1 sends 8'hA5 LSB first.
    byte_v = 8'hA5;
    wait_grant("data_wait_grant");
    check("data_grant", 32'(grant), 32'b010);
    slave_req = '0;
    nvalid = 0;
    bi = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (master_valid) begin
        nvalid++;
        check("data_id", 32'(master_slave_id), 32'd1);
        check("data_bit", 32'(master_rx_data), 32'(exp_q.pop_front()));
      end
      if (dbg_state == XFER && bi < 8) begin
        slave_tx_data[1] = byte_v[bi];
        exp_q.push_back(byte_v[bi]);
        bi++;
      end
    end
    check("data_nvalid", 32'(nvalid), 32'd8);
    check("data_q_empty", 32'(exp_q.size()), 32'd0);
    check("data_busy_end", 32'(busy), 32'd0);

    // master_ready low blocks arbitration; rising ready grants next cycle.
    slave_req    = 3'b001;
    master_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_grant", 32'(grant), 32'd0);
      check("hold_busy", 32'(busy), 32'd0);
    end
    master_ready = 1'b1;
    tick();
    check("ready_grant", 32'(grant), 32'b001);
    slave_req = '0;
    wait_idle(cyc);
    check("ready_frame_len", 32'(cyc), 32'd10);

    // Inputs dropped mid-XFER: frame still completes with 8 valid bits.
    slave_req = 3'b100;
    wait_grant("drop_wait_grant");
    check("drop_grant", 32'(grant), 32'b100);
    nvalid = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (master_valid) nvalid++;
      if (c == 3) begin
        slave_req    = '0;
        master_ready = 1'b0;
      end
    end
    check("drop_nvalid", 32'(nvalid), 32'd8);
    check("drop_busy_end", 32'(busy), 32'd0);

    // Reset at XFER bit 4 clears everything in the same cycle.
    slave_tx_data = 3'b111;
    slave_req     = 3'b001;
    master_ready  = 1'b1;
    wait_grant("mid_wait_grant");
    check("mid_grant", 32'(grant), 32'b001);
    repeat (5) tick();
    check("mid_state", 32'(dbg_state), 32'(XFER));
    check("mid_valid_pre", 32'(master_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_valid", 32'(master_valid), 32'd0);
    check("mid_rst_rxdata", 32'(master_rx_data), 32'd0);
    check("mid_rst_id", 32'(master_slave_id), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout_err), 32'd0);
    slave_req = 3'b110;
    tick();
    reset = 1'b0;
    wait_grant("post_rst_wait_grant");
    check("post_rst_grant", 32'(grant), 32'b010);
    slave_req = '0;
    wait_idle(cyc);
    check("post_rst_len", 32'(cyc), 32'd10);

    // Slave 0 never signals done after its frame.
    slave_tx_done = 3'b110;
    slave_req     = 3'b001;
    wait_grant("to_wait_grant");
    check("to_grant", 32'(grant), 32'b001);
    slave_req = '0;
    cyc = 0;
    while (dbg_state != RELEASE && cyc < 20) begin
      tick();
      cyc++;
    end
    check("to_reach_release", 32'(dbg_state), 32'(RELEASE));
`ifdef ARB_TIMEOUT_EN
    rel      = 0;
    pulses   = 0;
    pulse_at = 0;
    cyc      = 0;
    while (busy && cyc < 40) begin
      if (dbg_state == RELEASE) rel++;
      if (timeout_err) begin
        pulses++;
        pulse_at = rel;
      end
      tick();
      cyc++;
    end
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_pulse_at", 32'(pulse_at), 32'd16);
    check("to_release_cycles", 32'(rel), 32'd16);
    check("to_idle", 32'(busy), 32'd0);
    check("to_err_low", 32'(timeout_err), 32'd0);
    slave_tx_done = 3'b111;
`else
    stuck = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy && !timeout_err && dbg_state == RELEASE) stuck++;
    end
    check("noto_stuck", 32'(stuck), 32'd40);
    slave_tx_done = 3'b111;
    tick();
    tick();
    check("noto_released", 32'(busy), 32'd0);
`endif
    // Pointer moved past slave 0: with 0 and 1 requesting, slave 1 wins.
    slave_req = 3'b011;
    wait_grant("after_wait_grant");
    check("after_grant", 32'(grant), 32'b010);
    slave_req = '0;
    wait_idle(cyc);
    check("after_len", 32'(cyc), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on simulated time.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
